// File: rtl/instruction_fetch_unit_if.sv
// Fetch-unit bus bundle: program load, start/done handshake with the
// processor, and the issued word (DIN/Run/PC) plus Busy/Error status.
interface instruction_fetch_unit_if;
  logic       Load_en;
  logic [4:0] Load_addr;
  logic [8:0] Load_data;
  logic [5:0] Prog_len;
  logic       Start;
  logic       Done;
  logic [8:0] DIN;
  logic       Run;
  logic [4:0] PC;
  logic       Busy;
  logic       Error;

  modport master (
    output Load_en, Load_addr, Load_data,
    output Prog_len, Start, Done,
    input  DIN, Run, PC, Busy, Error
  );

  modport slave (
    input  Load_en, Load_addr, Load_data,
    input  Prog_len, Start, Done,
    output DIN, Run, PC, Busy, Error
  );
endinterface

// File: rtl/instruction_fetch_unit.sv
// Instruction fetch unit: 32x9 program memory, issues words to a processor
// and waits for Done; two-word mvi fetches its immediate from PC+1.
// Ports: Clock, Reset (sync, active-high), bus (slave modport):
//   in  Load_en/Load_addr/Load_data, Prog_len, Start, Done
//   out DIN, Run, PC, Busy, Error
// Optional watchdog: define IFU_TIMEOUT_EN.
module instruction_fetch_unit #(
  parameter logic [2:0] MVI_OPCODE     = 3'b001,
  parameter int         TIMEOUT_CYCLES = 16
) (
  input logic                       Clock,
  input logic                       Reset,
  instruction_fetch_unit_if.slave   bus
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_ISSUE,
    S_IMM,
    S_WAIT
  } state_t;

  state_t     state_q;
  logic [8:0] mem_q [32];
  logic [4:0] pc_q;
  logic [5:0] words_q;
  logic [5:0] len_q;
  logic [8:0] din_q;
  logic       run_q;
  logic       busy_q;

  logic [1:0] adv;
  logic [4:0] pc_inc;
  logic [4:0] pc_d;
  logic [5:0] words_d;
  logic       is_mvi;

  // An mvi retires two words (opcode + immediate), everything else one.
  assign adv     = (state_q == S_IMM) ? 2'd2 : 2'd1;
  assign pc_inc  = pc_q + 5'd1;
  assign pc_d    = pc_q + {3'b000, adv};
  assign words_d = words_q + {4'b0000, adv};
  assign is_mvi  = (mem_q[pc_q][8:6] == MVI_OPCODE);

  // Memory is not reset; loads only land while idle.
  always_ff @(posedge Clock) begin
    if (!Reset && bus.Load_en && state_q == S_IDLE)
      mem_q[bus.Load_addr] <= bus.Load_data;
  end

`ifdef IFU_TIMEOUT_EN
  localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
  logic [CW-1:0] cnt_q;
  logic          err_q;
`endif

  always_ff @(posedge Clock) begin
    if (Reset) begin
      state_q <= S_IDLE;
      pc_q    <= '0;
      words_q <= '0;
      len_q   <= '0;
      din_q   <= '0;
      run_q   <= 1'b0;
      busy_q  <= 1'b0;
`ifdef IFU_TIMEOUT_EN
      cnt_q   <= '0;
      err_q   <= 1'b0;
`endif
    end else begin
      unique case (state_q)
        S_IDLE: begin
          if (bus.Start && bus.Prog_len != 6'd0) begin
            len_q   <= bus.Prog_len;
            pc_q    <= '0;
            words_q <= '0;
            din_q   <= mem_q[0];
            run_q   <= 1'b1;
            busy_q  <= 1'b1;
            state_q <= S_ISSUE;
`ifdef IFU_TIMEOUT_EN
            err_q   <= 1'b0;
`endif
          end
        end
        S_ISSUE: begin
`ifdef IFU_TIMEOUT_EN
          cnt_q <= '0;
`endif
          if (is_mvi) begin
            din_q   <= mem_q[pc_inc];
            state_q <= S_IMM;
          end else begin
            state_q <= S_WAIT;
          end
        end
        S_IMM, S_WAIT: begin
          if (bus.Done) begin
            pc_q    <= pc_d;
            words_q <= words_d;
            // A trailing mvi may overshoot Prog_len by one word.
            if (words_d >= len_q) begin
              din_q   <= '0;
              run_q   <= 1'b0;
              busy_q  <= 1'b0;
              state_q <= S_IDLE;
            end else begin
              din_q   <= mem_q[pc_d];
              state_q <= S_ISSUE;
            end
          end
`ifdef IFU_TIMEOUT_EN
          else if (cnt_q == CW'(TIMEOUT_CYCLES - 1)) begin
            err_q   <= 1'b1;
            din_q   <= '0;
            run_q   <= 1'b0;
            busy_q  <= 1'b0;
            state_q <= S_IDLE;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
`endif
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign bus.DIN  = din_q;
  assign bus.Run  = run_q;
  assign bus.PC   = pc_q;
  assign bus.Busy = busy_q;
`ifdef IFU_TIMEOUT_EN
  assign bus.Error = err_q;
`else
  assign bus.Error = 1'b0;
`endif

endmodule

// File: tb/tb_instruction_fetch_unit.sv
// Scoreboard bench for instruction_fetch_unit: a memory model predicts
// each issued word, immediate and PC; results checked as Done is given.
module tb_instruction_fetch_unit;

  localparam int TO = 16;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  instruction_fetch_unit_if bus();

  instruction_fetch_unit dut (
    .Clock (clk),
    .Reset (rst),
    .bus   (bus)
  );

  typedef struct {
    logic [8:0] iw;
    logic [8:0] hw;
    logic [4:0] pc;
  } exp_t;

  exp_t       sb[$];
  logic [8:0] tb_mem [32];
  int         checks = 0;
  int         errors = 0;

  task automatic load(input int a, input logic [8:0] d);
    @(negedge clk);
    bus.Load_en   = 1'b1;
    bus.Load_addr = 5'(a);
    bus.Load_data = d;
    tb_mem[a]     = d;
    @(negedge clk);
    bus.Load_en   = 1'b0;
  endtask

  task automatic run_prog(input int len, input int d, input bit noise,
                          input int stop_pc, input bit ghost);
    int   pc;
    int   w;
    int   fpc;
    bit   bad;
    bit   stopped;
    exp_t e;
    sb.delete();
    pc = 0;
    w  = 0;
    while (w < len) begin
      e.iw = tb_mem[pc];
      e.pc = 5'(pc);
      if (tb_mem[pc][8:6] == 3'b001) begin
        e.hw = tb_mem[(pc + 1) % 32];
        pc = (pc + 2) % 32;
        w  = w + 2;
      end else begin
        e.hw = tb_mem[pc];
        pc = (pc + 1) % 32;
        w  = w + 1;
      end
      sb.push_back(e);
    end
    fpc = pc;
    stopped = 1'b0;
    @(negedge clk);
    bus.Prog_len = 6'(len);
    bus.Start    = 1'b1;
    @(negedge clk);
    bus.Start    = 1'b0;
    bus.Prog_len = 6'd0;
    while (sb.size() > 0 && !stopped) begin
      e = sb.pop_front();
      checks++;
      if (bus.DIN !== e.iw || bus.PC !== e.pc ||
          bus.Run !== 1'b1 || bus.Busy !== 1'b1) begin
        errors++;
        $display("FAIL issue pc=%0d: DIN=%h PC=%0d Run=%b Busy=%b want DIN=%h PC=%0d Run=1 Busy=1",
                 e.pc, bus.DIN, bus.PC, bus.Run, bus.Busy, e.iw, e.pc);
      end
      if (ghost) bus.Done = 1'b1;
      @(negedge clk);
      bus.Done = 1'b0;
      if (stop_pc == int'(e.pc)) begin
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        checks++;
        if (bus.Run !== 1'b0 || bus.PC !== 5'd0 ||
            bus.Busy !== 1'b0 || bus.DIN !== 9'd0) begin
          errors++;
          $display("FAIL mid_reset: Run=%b PC=%0d Busy=%b DIN=%h want 0 0 0 0",
                   bus.Run, bus.PC, bus.Busy, bus.DIN);
        end
        stopped = 1'b1;
      end else begin
        bad = 1'b0;
        for (int k = 0; k < d; k++) begin
          if (k > 0) @(negedge clk);
          if (bus.DIN !== e.hw || bus.Run !== 1'b1 || bus.PC !== e.pc)
            bad = 1'b1;
          if (noise) begin
            bus.Start     = 1'b1;
            bus.Prog_len  = 6'd1;
            bus.Load_en   = 1'b1;
            bus.Load_addr = e.pc;
            bus.Load_data = ~tb_mem[e.pc];
          end
        end
        checks++;
        if (bad) begin
          errors++;
          $display("FAIL hold pc=%0d: DIN=%h PC=%0d Run=%b want DIN=%h stable",
                   e.pc, bus.DIN, bus.PC, bus.Run, e.hw);
        end
        bus.Done = 1'b1;
        @(negedge clk);
        bus.Done     = 1'b0;
        bus.Start    = 1'b0;
        bus.Load_en  = 1'b0;
        bus.Prog_len = 6'd0;
      end
    end
    if (!stopped) begin
      checks++;
      if (bus.Busy !== 1'b0 || bus.Run !== 1'b0 || bus.DIN !== 9'd0 ||
          bus.PC !== 5'(fpc) || bus.Error !== 1'b0) begin
        errors++;
        $display("FAIL end: Busy=%b Run=%b DIN=%h PC=%0d Err=%b want 0 0 0 %0d 0",
                 bus.Busy, bus.Run, bus.DIN, bus.PC, bus.Error, fpc);
      end
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    checks++;
    if (bus.Busy !== 1'b0 || bus.Run !== 1'b0 || bus.DIN !== 9'd0 ||
        bus.PC !== 5'd0 || bus.Error !== 1'b0) begin
      errors++;
      $display("FAIL reset: Busy=%b Run=%b DIN=%h PC=%0d Err=%b want all 0",
               bus.Busy, bus.Run, bus.DIN, bus.PC, bus.Error);
    end
    load(0, 9'b010_000_000);
    bus.Prog_len = 6'd1;
    bus.Start    = 1'b1;
    rst          = 1'b1;
    @(negedge clk);
    rst          = 1'b0;
    bus.Start    = 1'b0;
    bus.Prog_len = 6'd0;
    checks++;
    if (bus.Busy !== 1'b0 || bus.Run !== 1'b0) begin
      errors++;
      $display("FAIL reset_prio: Busy=%b Run=%b want 0 0", bus.Busy, bus.Run);
    end
  endtask

  task automatic test_mvi();
    load(0, 9'b001_000_000);
    load(1, 9'b111_110_000);
    run_prog(2, 3, 1'b0, -1, 1'b0);
  endtask

  task automatic test_back_to_back();
    load(0, 9'b010_000_010);
    load(1, 9'b011_000_010);
    run_prog(2, 2, 1'b0, -1, 1'b1);
  endtask

  task automatic test_reset_mid();
    for (int i = 0; i < 5; i++)
      load(i, {3'b010, 1'b0, 5'(i + 3)});
    run_prog(5, 2, 1'b0, 3, 1'b0);
    run_prog(5, 1, 1'b0, -1, 1'b0);
  endtask

  task automatic test_ignored();
    @(negedge clk);
    bus.Prog_len = 6'd0;
    bus.Start    = 1'b1;
    @(negedge clk);
    bus.Start    = 1'b0;
    checks++;
    if (bus.Busy !== 1'b0 || bus.Run !== 1'b0 || bus.PC !== 5'd5) begin
      errors++;
      $display("FAIL zero_len: Busy=%b Run=%b PC=%0d want 0 0 5",
               bus.Busy, bus.Run, bus.PC);
    end
    run_prog(5, 3, 1'b1, -1, 1'b0);
    run_prog(5, 1, 1'b0, -1, 1'b0);
  endtask

  task automatic test_wrap();
    for (int i = 0; i < 31; i++)
      load(i, {3'b010, 1'b1, 5'(i)});
    load(31, 9'b001_000_111);
    run_prog(32, 1, 1'b0, -1, 1'b0);
  endtask

  task automatic test_timeout();
    int  k;
    bit  ok;
    load(0, 9'b100_000_001);
    @(negedge clk);
    bus.Prog_len = 6'd1;
    bus.Start    = 1'b1;
    @(negedge clk);
    bus.Start    = 1'b0;
    @(negedge clk);
`ifdef IFU_TIMEOUT_EN
    k = 0;
    while (k < 40 && bus.Error !== 1'b1) begin
      @(negedge clk);
      k++;
    end
    checks++;
    if (k != TO || bus.Run !== 1'b0 || bus.Busy !== 1'b0) begin
      errors++;
      $display("FAIL timeout: cycles=%0d Run=%b Busy=%b want %0d 0 0",
               k, bus.Run, bus.Busy, TO);
    end
    run_prog(1, 1, 1'b0, -1, 1'b0);
`else
    ok = 1'b1;
    k  = 0;
    repeat (120) begin
      @(negedge clk);
      k++;
      if (bus.Run !== 1'b1 || bus.Error !== 1'b0) ok = 1'b0;
    end
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL no_timeout: Run=%b Err=%b after %0d want 1 0",
               bus.Run, bus.Error, k);
    end
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    checks++;
    if (bus.Run !== 1'b0 || bus.Busy !== 1'b0) begin
      errors++;
      $display("FAIL no_timeout_rst: Run=%b Busy=%b want 0 0",
               bus.Run, bus.Busy);
    end
`endif
  endtask

  initial begin
    bus.Load_en   = 1'b0;
    bus.Load_addr = '0;
    bus.Load_data = '0;
    bus.Prog_len  = '0;
    bus.Start     = 1'b0;
    bus.Done      = 1'b0;
    test_reset();
    test_mvi();
    test_back_to_back();
    test_reset_mid();
    test_ignored();
    test_wrap();
    test_timeout();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
